// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the gpio_bank peripheral.
//   - Word-address offsets of each register group as functions of the
//     channel counts, so the top and any software-side model agree.
//   - Reset-value constant for every architectural register.
// Optional feature macro: GPIO_IRQ_EN (change-detect interrupt logic).
package gpio_pkg;

    // All registers (outputs, RD, status, mask, sync/history) reset to zero.
    localparam int RST_VAL = 0;

    // Input data channels start at word 0.
    function automatic int in_base();
        return 0;
    endfunction

    // Output data channels follow the inputs.
    function automatic int out_base(input int nin);
        return nin;
    endfunction

    // IRQ status sits right after the last output channel.
    function automatic int status_addr(input int nin, input int nout);
        return nin + nout;
    endfunction

    // IRQ mask follows the status register.
    function automatic int mask_addr(input int nin, input int nout);
        return nin + nout + 1;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: one input channel's two-flop synchroniser. With GPIO_IRQ_EN
// defined it also keeps a history copy of the synchronised value and flags
// any bit difference as a change.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   pin       : asynchronous input pins of this channel
//   val       : synchronised value (second flop)
//   change    : (GPIO_IRQ_EN only) val differs from its value a cycle ago
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] val
`ifdef GPIO_IRQ_EN
    ,
    output logic             change
`endif
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= WIDTH'(RST_VAL);
            s2 <= WIDTH'(RST_VAL);
        end else begin
            s1 <= pin;
            s2 <= s1;
        end
    end

    assign val = s2;

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] hist;

    always_ff @(posedge clk) begin
        if (rst) hist <= WIDTH'(RST_VAL);
        else     hist <= s2;
    end

    // Combinational so the status bit sets on the edge after s2 moves.
    assign change = (s2 != hist);
`endif

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO with NIN synchronised input channels and
// NOUT output channels of WIDTH bits, behind one word-addressed port.
// Map: 0..NIN-1 inputs (RO), NIN..NIN+NOUT-1 outputs (RW),
//      NIN+NOUT IRQ_STATUS (RO, W1C), NIN+NOUT+1 IRQ_MASK (RW), rest unmapped.
// Optional macro GPIO_IRQ_EN: change detection, status/mask and irq.
//   Without it the IRQ addresses read 0, writes are ignored, irq is 0.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   A        : word address;  WE/RE : write/read strobes;  WD : write data
//   RD       : registered read data (1-cycle latency, holds when RE=0)
//   gpI      : input pins, channel i at [i*WIDTH +: WIDTH]
//   gpO      : output registers, same packing
//   irq      : level interrupt, OR of (status & mask)
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NIN   = 2,
    parameter int NOUT  = 2,
    parameter int AW    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         A,
    input  logic                  WE,
    input  logic                  RE,
    input  logic [WIDTH-1:0]      WD,
    output logic [WIDTH-1:0]      RD,
    input  logic [NIN*WIDTH-1:0]  gpI,
    output logic [NOUT*WIDTH-1:0] gpO,
    output logic                  irq
);

    if (NIN < 1 || NIN > 16 || NOUT < 1 || NOUT > 16 ||
        NIN + NOUT + 2 > 2**AW || NIN > WIDTH) begin : g_bad_params
        $error("gpio_bank: NIN/NOUT out of range or map does not fit in AW");
    end

    logic [NIN-1:0][WIDTH-1:0]  sync_val;
    logic [NOUT-1:0][WIDTH-1:0] out_reg;
    logic [WIDTH-1:0]           rd_nxt;

`ifdef GPIO_IRQ_EN
    localparam logic [AW-1:0] STAT_A = AW'(status_addr(NIN, NOUT));
    localparam logic [AW-1:0] MASK_A = AW'(mask_addr(NIN, NOUT));
    logic [NIN-1:0] chg;
    logic [NIN-1:0] clr;
    logic [NIN-1:0] status;
    logic [NIN-1:0] mask;
`endif

    for (genvar i = 0; i < NIN; i++) begin : g_sync
        gpio_sync #(.WIDTH(WIDTH)) u_sync (
            .clk    (clk),
            .rst    (rst),
            .pin    (gpI[i*WIDTH +: WIDTH]),
            .val    (sync_val[i])
`ifdef GPIO_IRQ_EN
            ,
            .change (chg[i])
`endif
        );
    end

    // Output channel registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg <= '0;
        end else if (WE) begin
            for (int k = 0; k < NOUT; k++)
                if (A == AW'(out_base(NIN) + k)) out_reg[k] <= WD;
        end
    end

    assign gpO = out_reg;

`ifdef GPIO_IRQ_EN
    assign clr = (WE && A == STAT_A) ? WD[NIN-1:0] : '0;

    // OR-ing the change flags after the clear makes a same-cycle set win.
    always_ff @(posedge clk) begin
        if (rst) begin
            status <= '0;
            mask   <= '0;
        end else begin
            status <= (status & ~clr) | chg;
            if (WE && A == MASK_A) mask <= WD[NIN-1:0];
        end
    end

    assign irq = |(status & mask);
`else
    assign irq = 1'b0;
`endif

    // Read mux: unmapped addresses fall through to zero.
    always_comb begin
        rd_nxt = '0;
        for (int i = 0; i < NIN; i++)
            if (A == AW'(in_base() + i)) rd_nxt = sync_val[i];
        for (int k = 0; k < NOUT; k++)
            if (A == AW'(out_base(NIN) + k)) rd_nxt = out_reg[k];
`ifdef GPIO_IRQ_EN
        if (A == STAT_A) rd_nxt = WIDTH'(status);
        if (A == MASK_A) rd_nxt = WIDTH'(mask);
`endif
    end

    // Sampled from pre-edge state, so a same-cycle write reads the old value.
    always_ff @(posedge clk) begin
        if (rst)     RD <= WIDTH'(RST_VAL);
        else if (RE) RD <= rd_nxt;
    end

endmodule
